// File: rtl/arm_pkg.sv
// Shared constants and types for the pipelined ARM core front end.
package arm_pkg;

   localparam logic [31:0] NOP_BUBBLE        = 32'h0000_0000;
   localparam logic [31:0] HALT_WORD_DEFAULT = 32'hEAFF_FFFE;
   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls and imem word in, PC and IF/ID contents out.
interface fetch_stage_if #(
   parameter int CNT_W = 16
);
   logic                StallF;
   logic                StallD;
   logic                FlushD;
   logic                BranchTakenE;
   logic [31:0]         BranchTargetE;
   logic                PCSrcW;
   logic [31:0]         ResultW;
   logic [31:0]         InstrF;
   logic [31:0]         PCF;
   logic [31:0]         InstrD;
   logic                ValidD;
   logic [31:0]         PCD;
   logic [31:0]         PCPlus8D;
   logic                Halted;
   logic [CNT_W-1:0]    FetchCnt;

   modport master (
      output StallF, StallD, FlushD, BranchTakenE, BranchTargetE, PCSrcW, ResultW, InstrF,
      input  PCF, InstrD, ValidD, PCD, PCPlus8D, Halted, FetchCnt
   );

   modport slave (
      input  StallF, StallD, FlushD, BranchTakenE, BranchTargetE, PCSrcW, ResultW, InstrF,
      output PCF, InstrD, ValidD, PCD, PCPlus8D, Halted, FetchCnt
   );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// PC register: branch > writeback redirect > stall hold > sequential PC+4 (wraps mod 2^32).
module pc_reg
   import arm_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallF,
   input  logic        BranchTakenE,
   input  logic [31:0] BranchTargetE,
   input  logic        PCSrcW,
   input  logic [31:0] ResultW,
   output logic [31:0] PCF
);

   logic [31:0] pcNext;

   // Redirects beat the stall so a hazard hold can never swallow a taken branch.
   always_comb begin
      pcNext = PCF + 32'd4;
      if (BranchTakenE) begin
         pcNext = {BranchTargetE[31:2], 2'b00};
      end else if (PCSrcW) begin
         pcNext = {ResultW[31:2], 2'b00};
      end else if (StallF) begin
         pcNext = PCF;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         PCF <= RESET_PC;
      end else begin
         PCF <= pcNext;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage + IF/ID register: owns the PC, holds/flushes the fetched word, flags the halt loop.
module fetch_stage
   import arm_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT,
   parameter int          CNT_W     = 16
) (
   input logic          clk,
   input logic          rst,
   fetch_stage_if.slave bus
);

   logic [31:0]      pcF;
   logic [31:0]      instrD;
   logic             validD;
   logic [31:0]      pcD;
   logic [31:0]      pcPlus8D;
   logic [CNT_W-1:0] fetchCnt;
   fetch_state_e     state;
   fetch_state_e     stateNext;
   logic             redirect;
   logic             killD;
   logic             loadD;

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk           (clk),
      .rst           (rst),
      .StallF        (bus.StallF),
      .BranchTakenE  (bus.BranchTakenE),
      .BranchTargetE (bus.BranchTargetE),
      .PCSrcW        (bus.PCSrcW),
      .ResultW       (bus.ResultW),
      .PCF           (pcF)
   );

   // A redirect means the word fetched this cycle is wrong-path, so it is killed like a flush.
   assign redirect = bus.BranchTakenE | bus.PCSrcW;
   assign killD    = bus.FlushD | redirect;
   assign loadD    = !killD && !bus.StallD;

   always_ff @(posedge clk) begin
      if (rst || killD) begin
         instrD   <= NOP_BUBBLE;
         validD   <= 1'b0;
         pcD      <= 32'h0;
         pcPlus8D <= 32'd8;
      end else if (loadD) begin
         instrD   <= bus.InstrF;
         validD   <= 1'b1;
         pcD      <= pcF;
         pcPlus8D <= pcF + 32'd8;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetchCnt <= '0;
      end else if (loadD && (fetchCnt != {CNT_W{1'b1}})) begin
         fetchCnt <= fetchCnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      if ((state == RUN) && validD && (instrD == HALT_WORD)) begin
         stateNext = HALT;
      end
   end

   assign bus.PCF      = pcF;
   assign bus.InstrD   = instrD;
   assign bus.ValidD   = validD;
   assign bus.PCD      = pcD;
   assign bus.PCPlus8D = pcPlus8D;
   assign bus.Halted   = (state == HALT);
   assign bus.FetchCnt = fetchCnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed checks of fetch_stage: sequencing, stalls, redirects, flush, halt detection, wrap and reset.
module tb_fetch_stage;

   logic clk;
   logic rst;
   int   nCmp;
   int   nFail;

   fetch_stage_if #(.CNT_W(16)) fi ();

   fetch_stage #(
      .RESET_PC  (32'h0000_0000),
      .HALT_WORD (32'hEAFF_FFFE),
      .CNT_W     (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (fi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] imemWord(input logic [31:0] pc);
      return 32'hE1A0_0000 | {16'h0, pc[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clearCtl();
      fi.StallF        = 1'b0;
      fi.StallD        = 1'b0;
      fi.FlushD        = 1'b0;
      fi.BranchTakenE  = 1'b0;
      fi.BranchTargetE = 32'h0;
      fi.PCSrcW        = 1'b0;
      fi.ResultW       = 32'h0;
   endtask

   task automatic chkD(input string tag, input logic [31:0] pcf, input logic [31:0] instr,
                       input logic valid, input logic [31:0] pcd, input logic [31:0] cnt);
      chk({tag, ".PCF"},      fi.PCF, pcf);
      chk({tag, ".InstrD"},   fi.InstrD, instr);
      chk({tag, ".ValidD"},   {31'h0, fi.ValidD}, {31'h0, valid});
      chk({tag, ".PCD"},      fi.PCD, pcd);
      chk({tag, ".PCPlus8D"}, fi.PCPlus8D, pcd + 32'd8);
      chk({tag, ".FetchCnt"}, {16'h0, fi.FetchCnt}, cnt);
   endtask

   initial begin
      nCmp  = 0;
      nFail = 0;
      rst   = 1'b1;
      clearCtl();
      fi.InstrF = 32'h0;
      step();
      step();
      chkD("reset", 32'h0, 32'h0, 1'b0, 32'h0, 32'd0);
      chk("reset.Halted", {31'h0, fi.Halted}, 32'h0);

      // Free run
      rst = 1'b0;
      fi.InstrF = imemWord(fi.PCF);
      step(); chkD("run1", 32'h4, 32'hE1A0_0000, 1'b1, 32'h0, 32'd1);
      fi.InstrF = imemWord(fi.PCF);
      step(); chkD("run2", 32'h8, 32'hE1A0_0004, 1'b1, 32'h4, 32'd2);
      fi.InstrF = imemWord(fi.PCF);
      step(); chkD("run3", 32'hC, 32'hE1A0_0008, 1'b1, 32'h8, 32'd3);
      fi.InstrF = imemWord(fi.PCF);
      step(); chkD("run4", 32'h10, 32'hE1A0_000C, 1'b1, 32'hC, 32'd4);

      // Stall both stages for two cycles
      fi.StallF = 1'b1;
      fi.StallD = 1'b1;
      fi.InstrF = imemWord(fi.PCF);
      step(); chkD("stall1", 32'h10, 32'hE1A0_000C, 1'b1, 32'hC, 32'd4);
      step(); chkD("stall2", 32'h10, 32'hE1A0_000C, 1'b1, 32'hC, 32'd4);
      clearCtl();
      step(); chkD("unstall", 32'h14, 32'hE1A0_0010, 1'b1, 32'h10, 32'd5);

      // Branch beats writeback redirect and stall; target aligned
      fi.InstrF        = imemWord(fi.PCF);
      fi.BranchTakenE  = 1'b1;
      fi.BranchTargetE = 32'h43;
      fi.StallF        = 1'b1;
      fi.PCSrcW        = 1'b1;
      fi.ResultW       = 32'h80;
      step(); chkD("branch", 32'h40, 32'h0, 1'b0, 32'h0, 32'd5);
      clearCtl();
      fi.InstrF = imemWord(fi.PCF);
      step(); chkD("branchT", 32'h44, 32'hE1A0_0040, 1'b1, 32'h40, 32'd6);

      // Writeback redirect alone, unaligned result
      fi.InstrF  = imemWord(fi.PCF);
      fi.PCSrcW  = 1'b1;
      fi.ResultW = 32'h1F;
      step(); chkD("wbRedir", 32'h1C, 32'h0, 1'b0, 32'h0, 32'd6);
      clearCtl();

      // Flush together with StallD: flush wins
      fi.InstrF = imemWord(fi.PCF);
      fi.FlushD = 1'b1;
      fi.StallD = 1'b1;
      step(); chkD("flushStall", 32'h20, 32'h0, 1'b0, 32'h0, 32'd6);
      clearCtl();

      // Halt word at 0x20
      fi.InstrF = 32'hEAFF_FFFE;
      step(); chkD("haltD", 32'h24, 32'hEAFF_FFFE, 1'b1, 32'h20, 32'd7);
      chk("haltD.Halted", {31'h0, fi.Halted}, 32'h0);
      fi.InstrF = imemWord(fi.PCF);
      step(); chkD("halted", 32'h28, 32'hE1A0_0024, 1'b1, 32'h24, 32'd8);
      chk("halted.Halted", {31'h0, fi.Halted}, 32'h1);
      for (int i = 0; i < 20; i++) begin
         fi.InstrF = imemWord(fi.PCF);
         step();
         chk("haltSticky", {31'h0, fi.Halted}, 32'h1);
      end
      chk("haltRun.PCF", fi.PCF, 32'h78);
      chk("haltRun.FetchCnt", {16'h0, fi.FetchCnt}, 32'd28);
      rst = 1'b1;
      step();
      chk("rstHalt.Halted", {31'h0, fi.Halted}, 32'h0);
      chkD("rstHalt", 32'h0, 32'h0, 1'b0, 32'h0, 32'd0);
      rst = 1'b0;

      // PC wrap at top of address space
      fi.InstrF  = imemWord(fi.PCF);
      fi.PCSrcW  = 1'b1;
      fi.ResultW = 32'hFFFF_FFFC;
      step(); chkD("toTop", 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0, 32'd0);
      clearCtl();
      fi.InstrF = imemWord(fi.PCF);
      step(); chkD("wrap", 32'h0, 32'hE1A0_FFFC, 1'b1, 32'hFFFF_FFFC, 32'd1);
      chk("wrap.PCPlus8D", fi.PCPlus8D, 32'h4);

      // Reset during a redirect drops the redirect
      fi.InstrF        = imemWord(fi.PCF);
      fi.BranchTakenE  = 1'b1;
      fi.BranchTargetE = 32'h100;
      rst = 1'b1;
      step(); chkD("rstRedir", 32'h0, 32'h0, 1'b0, 32'h0, 32'd0);
      chk("rstRedir.Halted", {31'h0, fi.Halted}, 32'h0);
      rst = 1'b0;
      clearCtl();
      fi.InstrF = imemWord(fi.PCF);
      step(); chkD("postRst", 32'h4, 32'hE1A0_0000, 1'b1, 32'h0, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
